sti_dac_param: RTL and testbench
================================

Name: sti_dac_param

Overview:
Parametrised successor of the team's serial-transmitter / data-arrangement-converter block. Accepts parallel words through a load/ready handshake and serialises each one as a frame with configurable length, justification, fill and bit order. The same bit stream is packed into OW-bit bytes and written in a checkerboard pattern across NBANK odd/even memory pairs. On end-of-stream, the remaining memory is zero-flushed and completion is signalled.

Parameters:
DW, 16, input word width; must be even, >= 8.
OW, 8, memory word (byte) width; must divide DW/2.
NBANK, 4, number of odd/even memory pairs.
DEPTH, 32, words per memory; power of two.
AW, $clog2(DEPTH), address width (derived).

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
load  input  1  frame request; accepted when load && pi_ready.
pi_ready  output  1  block idle, can accept a frame.
pi_data  input  DW  parallel data.
pi_length  input  2  frame length code L; frame bits FB = (L+1)*DW/2.
pi_fill  input  1  L>=2: 1 = data at MSB end, zeros below; 0 = zeros above data.
pi_msb  input  1  1 = MSB-first, 0 = LSB-first.
pi_low  input  1  L=0: 1 = send pi_data[DW-1:DW/2], 0 = send lower half.
pi_end  input  1  sampled with accepted load; marks the last frame.
so_data  output  1  serial bit.
so_valid  output  1  so_data valid this cycle.
oem_dataout  output  OW  byte to memory.
oem_addr  output  AW  memory address.
odd_wr  output  NBANK  one-hot odd-memory write strobe.
even_wr  output  NBANK  one-hot even-memory write strobe.
oem_finish  output  1  sticky completion flag.

Behaviour:
- Reset values: all outputs 0 except pi_ready = 1; state IDLE; byte index k = 0.
- FSM states:
  - IDLE: pi_ready = 1. On accept, latch the justified frame into a 4*DW/2-bit register and go to SHIFT.
  - SHIFT: one bit per cycle, so_valid = 1 for exactly FB consecutive cycles. The first bit is driven the cycle after accept. After the last bit, go to IDLE, or to FLUSH if pi_end was latched.
  - FLUSH: zero-pad any partial byte, then write 0-bytes, one per cycle, until k wraps past 2*NBANK*DEPTH-1, then go to DONE.
  - DONE: oem_finish = 1 and pi_ready = 0 until reset.
- Back-to-back frames: pi_ready returns high in the cycle after the last bit. Minimum gap between frames is 1 idle cycle.
- Packing:
  - Stream bit i of each byte goes to oem_dataout[OW-1-i].
  - On byte completion, next cycle: one strobe is high for one cycle, with oem_dataout and oem_addr valid in that same cycle.
  - Bank = k / (2*DEPTH); j = k mod 2*DEPTH; oem_addr = j>>1.
  - Memory select: even when j[0] XOR (j/8)[0], else odd. So row 0 goes odd, even, odd, even…; row 1 goes even, odd, ….
- k increments per written byte. If k reaches capacity before pi_end, set oem_finish, suppress further writes, but still serialise frames normally.
- Reset mid-frame: aborts immediately; no strobe in the cycle after reset.
- load while not pi_ready is ignored. Inputs other than load are sampled only at accept.

Optional Feature:
SO_PARITY_EN. Defined: after the FB data bits, one extra so_valid cycle carries even parity of the frame's FB bits. The parity bit is not packed into memory. Undefined: no parity cycle, and the frame is exactly FB cycles.

Decomposition:
Package sti_dac_pkg holds:
- state enum (IDLE, SHIFT, FLUSH, DONE);
- length-code constants;
- function frame_bits(L, DW).

One sub-module, sti_oem_packer, owns byte assembly, k counter, bank/address/checkerboard decode, strobes and flush sequencing. The top level holds the FSM, justification and shifter.

Test Plan:
- DW=16, pi_data=16'hA5C3, L=0, pi_low=1, pi_msb=1 -> so_data 1,0,1,0,0,1,0,1 over 8 cycles starting 1 cycle after accept; next cycle odd_wr[0]=1, oem_addr=0, oem_dataout=8'hA5.
- Same data, L=0, pi_low=0, pi_msb=0 -> bits 1,1,0,0,0,0,1,1; byte 8'hC3 written to even memory (k=1) at addr 0.
- L=2, pi_fill=1, pi_data=16'h1234, MSB-first -> 24 so_valid cycles, bytes 8'h12, 8'h34, 8'h00 at k=0,1,2.
- 8 bytes, then byte 8 -> byte 8 written to even_wr[0], addr 4 (row 1 starts even).
- pi_end on first 8-bit frame -> 255 zero writes follow (k=1..255), banks 0..3 in order; then oem_finish=1 and pi_ready=0.
- Reset asserted during SHIFT bit 5 -> next cycle so_valid=0, all strobes 0, pi_ready=1, k=0.

Source files
------------

// File: rtl/sti_dac_pkg.sv
// Shared types and helpers for the sti_dac_param serialiser/packer slice.
package sti_dac_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFlush,
    StDone
  } state_e;

  localparam logic [1:0] LenHalf    = 2'd0;
  localparam logic [1:0] LenFull    = 2'd1;
  localparam logic [1:0] LenOneHalf = 2'd2;
  localparam logic [1:0] LenDouble  = 2'd3;

  // Checkerboard row length is 8 bytes; the row parity bit is k[3].
  localparam int unsigned RowShift = 3;

  function automatic int unsigned frame_bits(input logic [1:0] len, input int unsigned dw);
    return (32'(len) + 32'd1) * dw / 32'd2;
  endfunction

endpackage

// File: rtl/sti_oem_packer.sv
// Packs the serial stream into OW-bit bytes and writes them checkerboard-wise
// across NBANK odd/even memory pairs; zero-flushes the remainder on request.
module sti_oem_packer
  import sti_dac_pkg::*;
#(
  parameter int unsigned OW    = 8,
  parameter int unsigned NBANK = 4,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             bit_valid_i,
  input  logic             bit_i,
  input  logic             flush_i,
  output logic             full_o,
  output logic [OW-1:0]    data_o,
  output logic [AW-1:0]    addr_o,
  output logic [NBANK-1:0] odd_wr_o,
  output logic [NBANK-1:0] even_wr_o
);

  localparam int unsigned Cap = 2 * NBANK * DEPTH;
  localparam int unsigned KW  = $clog2(Cap) + 1;
  localparam int unsigned BW  = $clog2(OW);

  logic [OW-1:0]    byte_q, byte_d, byte_n, wdata;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [KW-1:0]    k_q, k_d, bank;
  logic [OW-1:0]    data_q, data_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [NBANK-1:0] odd_q, odd_d, even_q, even_d, bank_oh;
  logic             we, sel_even;

  always_comb begin
    byte_d   = byte_q;
    bcnt_d   = bcnt_q;
    k_d      = k_q;
    data_d   = data_q;
    addr_d   = addr_q;
    odd_d    = '0;
    even_d   = '0;
    we       = 1'b0;
    wdata    = '0;
    byte_n   = byte_q;
    full_o   = (k_q == KW'(Cap));
    bank     = k_q >> (AW + 1);
    bank_oh  = NBANK'(1) << bank;
    sel_even = k_q[0] ^ k_q[RowShift];

    if (bit_valid_i) begin
      byte_n[BW'(OW - 1) - bcnt_q] = bit_i;
      if (bcnt_q == BW'(OW - 1)) begin
        we     = 1'b1;
        wdata  = byte_n;
        byte_d = '0;
        bcnt_d = '0;
      end else begin
        byte_d = byte_n;
        bcnt_d = bcnt_q + 1'b1;
      end
    end else if (flush_i) begin
      // Unfilled low bits are already zero, so a partial byte and a
      // pure zero byte are written the same way.
      we     = 1'b1;
      wdata  = byte_q;
      byte_d = '0;
      bcnt_d = '0;
    end

    if (we && !full_o) begin
      data_d = wdata;
      addr_d = k_q[AW:1];
      if (sel_even) even_d = bank_oh;
      else          odd_d  = bank_oh;
      k_d = k_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      byte_q <= '0;
      bcnt_q <= '0;
      k_q    <= '0;
      data_q <= '0;
      addr_q <= '0;
      odd_q  <= '0;
      even_q <= '0;
    end else begin
      byte_q <= byte_d;
      bcnt_q <= bcnt_d;
      k_q    <= k_d;
      data_q <= data_d;
      addr_q <= addr_d;
      odd_q  <= odd_d;
      even_q <= even_d;
    end
  end

  assign data_o    = data_q;
  assign addr_o    = addr_q;
  assign odd_wr_o  = odd_q;
  assign even_wr_o = even_q;

endmodule

// File: rtl/sti_dac_param.sv
// Parametrised serial transmitter / data-arrangement converter top level.
// Define SO_PARITY_EN to append an even-parity bit to every serial frame.
module sti_dac_param
  import sti_dac_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned OW    = 8,
  parameter int unsigned NBANK = 4,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  output logic             pi_ready,
  input  logic [DW-1:0]    pi_data,
  input  logic [1:0]       pi_length,
  input  logic             pi_fill,
  input  logic             pi_msb,
  input  logic             pi_low,
  input  logic             pi_end,
  output logic             so_data,
  output logic             so_valid,
  output logic [OW-1:0]    oem_dataout,
  output logic [AW-1:0]    oem_addr,
  output logic [NBANK-1:0] odd_wr,
  output logic [NBANK-1:0] even_wr,
  output logic             oem_finish
);

  localparam int unsigned FW = 2 * DW;
  localparam int unsigned CW = $clog2(FW + 1);

  state_e        state_q, state_d;
  logic [FW-1:0] frame_q, frame_d, just_val;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          msb_q, msb_d, end_q, end_d;
  logic          bit_valid, flush, full;
  int unsigned   fb;
`ifdef SO_PARITY_EN
  logic          par_q, par_d, par_ph_q, par_ph_d;
`endif

  // Frame held right-aligned; MSB-first frames are pre-shifted to the top.
  always_comb begin
    fb = frame_bits(pi_length, DW);
    case (pi_length)
      LenHalf:    just_val = pi_low ? FW'(pi_data[DW-1:DW/2]) : FW'(pi_data[DW/2-1:0]);
      LenFull:    just_val = FW'(pi_data);
      LenOneHalf: just_val = pi_fill ? FW'({pi_data, {(DW/2){1'b0}}}) : FW'(pi_data);
      default:    just_val = pi_fill ? {pi_data, {DW{1'b0}}} : FW'(pi_data);
    endcase
    if (pi_msb) just_val = just_val << (FW - fb);
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    cnt_d     = cnt_q;
    msb_d     = msb_q;
    end_d     = end_q;
    pi_ready  = 1'b0;
    so_valid  = 1'b0;
    so_data   = 1'b0;
    bit_valid = 1'b0;
    flush     = 1'b0;
`ifdef SO_PARITY_EN
    par_d     = par_q;
    par_ph_d  = par_ph_q;
`endif
    unique case (state_q)
      StIdle: begin
        pi_ready = 1'b1;
        if (load) begin
          frame_d = just_val;
          cnt_d   = CW'(fb);
          msb_d   = pi_msb;
          end_d   = pi_end;
          state_d = StShift;
`ifdef SO_PARITY_EN
          par_d    = 1'b0;
          par_ph_d = 1'b0;
`endif
        end
      end
      StShift: begin
        so_valid = 1'b1;
`ifdef SO_PARITY_EN
        if (par_ph_q) begin
          so_data  = par_q;
          par_ph_d = 1'b0;
          state_d  = end_q ? StFlush : StIdle;
        end else begin
          so_data   = msb_q ? frame_q[FW-1] : frame_q[0];
          bit_valid = 1'b1;
          frame_d   = msb_q ? (frame_q << 1) : (frame_q >> 1);
          cnt_d     = cnt_q - 1'b1;
          par_d     = par_q ^ so_data;
          if (cnt_q == CW'(1)) par_ph_d = 1'b1;
        end
`else
        so_data   = msb_q ? frame_q[FW-1] : frame_q[0];
        bit_valid = 1'b1;
        frame_d   = msb_q ? (frame_q << 1) : (frame_q >> 1);
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = end_q ? StFlush : StIdle;
`endif
      end
      StFlush: begin
        flush = 1'b1;
        if (full) state_d = StDone;
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      frame_q <= '0;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
      end_q   <= end_d;
    end
  end

`ifdef SO_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q    <= 1'b0;
      par_ph_q <= 1'b0;
    end else begin
      par_q    <= par_d;
      par_ph_q <= par_ph_d;
    end
  end
`endif

  sti_oem_packer #(
    .OW   (OW),
    .NBANK(NBANK),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_packer (
    .clk_i      (clk),
    .reset_i    (reset),
    .bit_valid_i(bit_valid),
    .bit_i      (so_data),
    .flush_i    (flush),
    .full_o     (full),
    .data_o     (oem_dataout),
    .addr_o     (oem_addr),
    .odd_wr_o   (odd_wr),
    .even_wr_o  (even_wr)
  );

  // Finish is sticky: capacity never decreases and DONE exits only on reset.
  assign oem_finish = full | (state_q == StDone);

endmodule

// File: tb/tb_sti_dac_param.sv
// Self-checking bench for sti_dac_param: vector table plus scoreboard queues.
module tb_sti_dac_param;

  localparam int DW = 16, OW = 8, NBANK = 4, DEPTH = 32, AW = 5, CAP = 256;

  logic             clk = 1'b0;
  logic             reset, load, pi_ready, pi_fill, pi_msb, pi_low, pi_end;
  logic [DW-1:0]    pi_data;
  logic [1:0]       pi_length;
  logic             so_data, so_valid, oem_finish;
  logic [OW-1:0]    oem_dataout;
  logic [AW-1:0]    oem_addr;
  logic [NBANK-1:0] odd_wr, even_wr;

  always #5 clk = ~clk;

  sti_dac_param #(.DW(DW), .OW(OW), .NBANK(NBANK), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .load(load), .pi_ready(pi_ready), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low),
    .pi_end(pi_end), .so_data(so_data), .so_valid(so_valid), .oem_dataout(oem_dataout),
    .oem_addr(oem_addr), .odd_wr(odd_wr), .even_wr(even_wr), .oem_finish(oem_finish)
  );

  typedef struct packed {
    logic [3:0] odd;
    logic [3:0] even;
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  len;
    logic        fill;
    logic        msb;
    logic        low;
    int          n;
    logic [31:0] bits;  // expected serial bits, first bit at bits[n-1]
  } vec_t;

  logic       bitq[$];
  wr_t        wrq[$];
  int         checks = 0, errors = 0;
  int         mk, mcnt;
  logic [7:0] mbyte;
  logic       mon_b;
  wr_t        mon_w, mon_a;
  vec_t       vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_write(input logic [7:0] d);
    wr_t w;
    int  j, bank;
    logic ev;
    j      = mk % (2 * DEPTH);
    bank   = mk / (2 * DEPTH);
    ev     = ((j % 2) != ((j / 8) % 2));
    w.data = d;
    w.addr = AW'(j / 2);
    w.odd  = ev ? 4'b0 : 4'(1 << bank);
    w.even = ev ? 4'(1 << bank) : 4'b0;
    wrq.push_back(w);
    mk++;
  endfunction

  function automatic void model_bit(input logic b);
    bitq.push_back(b);
    mbyte[7-mcnt] = b;
    mcnt++;
    if (mcnt == 8) begin
      if (mk < CAP) push_write(mbyte);
      mcnt  = 0;
      mbyte = '0;
    end
  endfunction

  function automatic void push_frame(input logic [31:0] bits, input int n, input logic last);
    for (int i = n - 1; i >= 0; i--) model_bit(bits[i]);
`ifdef SO_PARITY_EN
    bitq.push_back(^bits);
`endif
    if (last) begin
      if (mcnt != 0 && mk < CAP) push_write(mbyte);
      mcnt  = 0;
      mbyte = '0;
      while (mk < CAP) push_write(8'h00);
    end
  endfunction

  task automatic model_clear();
    bitq.delete();
    wrq.delete();
    mk    = 0;
    mcnt  = 0;
    mbyte = '0;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!pi_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!pi_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got pi_ready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic [1:0] len, input logic fill,
                       input logic msb, input logic low, input logic last);
    pi_data   = d;
    pi_length = len;
    pi_fill   = fill;
    pi_msb    = msb;
    pi_low    = low;
    pi_end    = last;
    load      = 1'b1;
  endtask

  task automatic send(input logic [15:0] d, input logic [1:0] len, input logic fill,
                      input logic msb, input logic low, input int n,
                      input logic [31:0] bits, input logic last);
    wait_ready();
    drive(d, len, fill, msb, low, last);
    push_frame(bits, n, last);
    @(posedge clk);
    #1 load = 1'b0;
    pi_end = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  // Scoreboard consumer: every serial bit and every strobe must be expected.
  always @(negedge clk) begin
    if (!reset) begin
      if (so_valid) begin
        if (bitq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL so_data: got unexpected bit %b expected no so_valid", so_data);
        end else begin
          mon_b = bitq.pop_front();
          check("so_data", 32'(so_data), 32'(mon_b));
        end
      end
      if (|odd_wr || |even_wr) begin
        mon_a = {odd_wr, even_wr, oem_addr, oem_dataout};
        if (wrq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_write: got unexpected write %0h expected none", mon_a);
        end else begin
          mon_w = wrq.pop_front();
          check("mem_write", 32'(mon_a), 32'(mon_w));
        end
      end
    end
  end

  initial begin
    vecs[0] = '{16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1, 8,  32'h0000_00A5};
    vecs[1] = '{16'hA5C3, 2'd0, 1'b0, 1'b0, 1'b0, 8,  32'h0000_00C3};
    vecs[2] = '{16'h1234, 2'd2, 1'b1, 1'b1, 1'b0, 24, 32'h0012_3400};
    vecs[3] = '{16'h1234, 2'd1, 1'b0, 1'b0, 1'b0, 16, 32'h0000_2C48};
    vecs[4] = '{16'hBEEF, 2'd3, 1'b0, 1'b1, 1'b0, 32, 32'h0000_BEEF};
    vecs[5] = '{16'h00F1, 2'd2, 1'b0, 1'b0, 1'b0, 24, 32'h008F_0000};
    vecs[6] = '{16'h8001, 2'd3, 1'b1, 1'b0, 1'b0, 32, 32'h0000_8001};
    vecs[7] = '{16'h1F07, 2'd0, 1'b0, 1'b0, 1'b1, 8,  32'h0000_00F8};

    load = 1'b0; pi_data = '0; pi_length = '0; pi_fill = 1'b0;
    pi_msb = 1'b0; pi_low = 1'b0; pi_end = 1'b0;
    do_reset();

    @(negedge clk);
    check("rst_pi_ready", 32'(pi_ready), 32'd1);
    check("rst_so_valid", 32'(so_valid), 32'd0);
    check("rst_odd_wr", 32'(odd_wr), 32'd0);
    check("rst_even_wr", 32'(even_wr), 32'd0);
    check("rst_finish", 32'(oem_finish), 32'd0);
    check("rst_addr", 32'(oem_addr), 32'd0);
    check("rst_data", 32'(oem_dataout), 32'd0);

    for (int i = 0; i < 8; i++)
      send(vecs[i].data, vecs[i].len, vecs[i].fill, vecs[i].msb, vecs[i].low,
           vecs[i].n, vecs[i].bits, 1'b0);
    wait_ready();
    @(negedge clk);
    check("table_bits_drained", 32'(bitq.size()), 32'd0);
    check("table_writes_drained", 32'(wrq.size()), 32'd0);

    // Reset during bit 5 of a 16-bit frame.
    wait_ready();
    drive(16'hF00F, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    push_frame(32'h0000_F00F, 16, 1'b0);
    @(posedge clk);
    #1 load = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    @(negedge clk);
    check("midrst_so_valid", 32'(so_valid), 32'd0);
    check("midrst_odd_wr", 32'(odd_wr), 32'd0);
    check("midrst_even_wr", 32'(even_wr), 32'd0);
    check("midrst_pi_ready", 32'(pi_ready), 32'd1);

    // End of stream on the first byte: data byte at k=0, then 255 zero bytes.
    send(16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1, 8, 32'h0000_00A5, 1'b1);
    for (int t = 0; t < 400 && wrq.size() != 0; t++) @(negedge clk);
    check("flush_writes_drained", 32'(wrq.size()), 32'd0);
    repeat (2) @(negedge clk);
    check("flush_finish", 32'(oem_finish), 32'd1);
    check("flush_pi_ready", 32'(pi_ready), 32'd0);
    load = 1'b1;
    repeat (2) @(negedge clk);
    load = 1'b0;
    check("done_ignores_load", 32'(so_valid), 32'd0);

    // Fill memory without pi_end, then keep serialising with writes suppressed.
    do_reset();
    for (int i = 0; i < 127; i++) begin
      pi_data = 16'($urandom);
      send(pi_data, 2'd1, 1'b0, 1'b1, 1'b0, 16, 32'(pi_data), 1'b0);
    end
    wait_ready();
    check("cap_minus2_finish", 32'(oem_finish), 32'd0);
    pi_data = 16'($urandom);
    send(pi_data, 2'd1, 1'b0, 1'b1, 1'b0, 16, 32'(pi_data), 1'b0);
    wait_ready();
    check("cap_finish", 32'(oem_finish), 32'd1);
    check("cap_pi_ready", 32'(pi_ready), 32'd1);
    send(16'h5A3C, 2'd1, 1'b0, 1'b1, 1'b0, 16, 32'h0000_5A3C, 1'b0);
    wait_ready();
    check("cap_bits_drained", 32'(bitq.size()), 32'd0);
    check("cap_no_writes", 32'(wrq.size()), 32'd0);
    send(16'h00C3, 2'd0, 1'b0, 1'b1, 1'b0, 8, 32'h0000_00C3, 1'b1);
    repeat (12) @(negedge clk);
    check("cap_end_pi_ready", 32'(pi_ready), 32'd0);
    check("cap_end_finish", 32'(oem_finish), 32'd1);
    check("final_bits_drained", 32'(bitq.size()), 32'd0);
    check("final_writes_drained", 32'(wrq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
